// File: rtl/zavala_pkg.sv
// Shared definitions for the zavala miner host poller: register map, status bits, FSM states.
package zavala_pkg;

   localparam logic [4:0] ADDR_STATUS = 5'd0;
   localparam logic [4:0] ADDR_NONCE  = 5'd1;
   localparam logic [4:0] ADDR_HASH0  = 5'd2;

   localparam int STAT_BUSY_BIT  = 0;
   localparam int STAT_FOUND_BIT = 1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_KICK,
      S_WAIT,
      S_POLL_RD,
      S_POLL_CHK,
      S_FETCH_RD,
      S_FETCH_CAP,
      S_EMIT,
      S_CLEAR
   } poll_state_t;

   // Word index 0 is the nonce; hash words follow at ascending addresses.
   function automatic logic [4:0] word_addr(input logic [4:0] idx);
      return ADDR_NONCE + idx;
   endfunction

endpackage

// File: rtl/zavala_host_poller_if.sv
// Miner register port plus the result stream, grouped for the host poller.
interface zavala_host_poller_if;
   logic        read;
   logic        write;
   logic [4:0]  op_address;
   logic [31:0] readdata;
   logic [31:0] res_data;
   logic        res_valid;
   logic        res_ready;
   logic        res_last;

   modport master (
      output read, write, op_address, res_data, res_valid, res_last,
      input  readdata, res_ready
   );

   modport slave (
      input  read, write, op_address, res_data, res_valid, res_last,
      output readdata, res_ready
   );
endinterface

// File: rtl/zavala_poll_timer.sv
// Loadable down-counter with zero flag; paces the idle gap between status polls.
module zavala_poll_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/zavala_host_poller.sv
// Host-side poller for the zavala miner: kick, poll status, stream nonce+hash, clear.
// Optional poll timeout enabled by defining ZAVALA_POLL_TIMEOUT_EN.
//
// state       | meaning
// S_IDLE      | waiting for start
// S_KICK      | write STATUS to launch a job
// S_WAIT      | idle gap before the next status read
// S_POLL_RD   | read strobe on STATUS
// S_POLL_CHK  | readdata holds STATUS; decide found / keep polling / time out
// S_FETCH_RD  | read strobe on NONCE or a HASH word
// S_FETCH_CAP | readdata holds the word; load result register
// S_EMIT      | result word presented, waiting for res_ready
// S_CLEAR     | write NONCE to clear the miner
module zavala_host_poller
   import zavala_pkg::*;
#(
   parameter int POLL_INTERVAL = 1000,
   parameter int HASH_WORDS    = 8,
   parameter int TIMEOUT_POLLS = 65536
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic abort,
   output logic busy,
   output logic done,
   output logic timeout,
   zavala_host_poller_if.master bus
);

   localparam int IW = $clog2(HASH_WORDS + 2);
   localparam int TW = (POLL_INTERVAL < 1) ? 1 : $clog2(POLL_INTERVAL + 1);
   // The POLL_CHK cycle already counts as one idle cycle, so the post-check gap is one shorter.
   localparam int LD_KICK = (POLL_INTERVAL >= 1) ? POLL_INTERVAL - 1 : 0;
   localparam int LD_CHK  = (POLL_INTERVAL >= 2) ? POLL_INTERVAL - 2 : 0;
   localparam logic [IW-1:0] LAST_IDX = IW'(HASH_WORDS);

   poll_state_t   state;
   logic [IW-1:0] idx;
   logic          read_q;
   logic          write_q;
   logic [4:0]    addr_q;
   logic [31:0]   data_q;
   logic          valid_q;
   logic          last_q;

   logic          tmr_load;
   logic          tmr_en;
   logic [TW-1:0] tmr_val;
   logic          tmr_zero;

   assign tmr_load = (state != S_WAIT);
   assign tmr_en   = (state == S_WAIT);
   assign tmr_val  = (state == S_KICK) ? TW'(LD_KICK) : TW'(LD_CHK);

   zavala_poll_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .en       (tmr_en),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

`ifdef ZAVALA_POLL_TIMEOUT_EN
   logic [16:0] polls;
   logic        timeout_q;
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         idx     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= ADDR_STATUS;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
`ifdef ZAVALA_POLL_TIMEOUT_EN
         polls     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         read_q  <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= ADDR_STATUS;
         done    <= 1'b0;
`ifdef ZAVALA_POLL_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         if (abort) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            idx     <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     state   <= S_KICK;
                     busy    <= 1'b1;
                     write_q <= 1'b1;
                     addr_q  <= ADDR_STATUS;
`ifdef ZAVALA_POLL_TIMEOUT_EN
                     polls   <= '0;
`endif
                  end
               end
               S_KICK: begin
                  if (POLL_INTERVAL == 0) begin
                     state  <= S_POLL_RD;
                     read_q <= 1'b1;
                  end else begin
                     state  <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (tmr_zero) begin
                     state  <= S_POLL_RD;
                     read_q <= 1'b1;
                  end
               end
               S_POLL_RD: begin
                  state <= S_POLL_CHK;
`ifdef ZAVALA_POLL_TIMEOUT_EN
                  polls <= polls + 17'd1;
`endif
               end
               S_POLL_CHK: begin
                  if (bus.readdata[STAT_FOUND_BIT]) begin
                     state  <= S_FETCH_RD;
                     idx    <= '0;
                     read_q <= 1'b1;
                     addr_q <= ADDR_NONCE;
`ifdef ZAVALA_POLL_TIMEOUT_EN
                  end else if (polls == 17'(TIMEOUT_POLLS)) begin
                     state     <= S_CLEAR;
                     write_q   <= 1'b1;
                     addr_q    <= ADDR_NONCE;
                     timeout_q <= 1'b1;
`endif
                  end else if (POLL_INTERVAL <= 1) begin
                     state  <= S_POLL_RD;
                     read_q <= 1'b1;
                  end else begin
                     state  <= S_WAIT;
                  end
               end
               S_FETCH_RD: begin
                  state <= S_FETCH_CAP;
               end
               S_FETCH_CAP: begin
                  data_q  <= bus.readdata;
                  valid_q <= 1'b1;
                  last_q  <= (idx == LAST_IDX);
                  state   <= S_EMIT;
               end
               S_EMIT: begin
                  if (bus.res_ready) begin
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     if (last_q) begin
                        state   <= S_CLEAR;
                        write_q <= 1'b1;
                        addr_q  <= ADDR_NONCE;
                        done    <= 1'b1;
                     end else begin
                        state  <= S_FETCH_RD;
                        idx    <= idx + IW'(1);
                        read_q <= 1'b1;
                        addr_q <= word_addr(5'(idx + IW'(1)));
                     end
                  end
               end
               S_CLEAR: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.read       = read_q;
   assign bus.write      = write_q;
   assign bus.op_address = addr_q;
   assign bus.res_data   = data_q;
   assign bus.res_valid  = valid_q;
   assign bus.res_last   = last_q;

endmodule

// File: tb/tb_zavala_host_poller.sv
// Scoreboard bench for zavala_host_poller with a behavioural miner model and random data/backpressure.
module tb_zavala_host_poller;
   import zavala_pkg::*;

   localparam int P  = 4;
   localparam int H  = 8;
   localparam int TP = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic busy, done, timeout;

   zavala_host_poller_if bus();

   zavala_host_poller #(.POLL_INTERVAL(P), .HASH_WORDS(H), .TIMEOUT_POLLS(TP)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .abort   (abort),
      .busy    (busy),
      .done    (done),
      .timeout (timeout),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   typedef struct { bit wr; logic [4:0] addr; } acc_t;
   typedef struct { logic [31:0] d; bit last; } word_t;
   acc_t  exp_acc[$];
   word_t exp_words[$];

   // ---------------- miner model ----------------
   logic [31:0] m_nonce;
   logic [31:0] m_hash [H];
   int          m_found_after = 1;
   int          m_reads = 0;
   bit          pend = 0;
   logic [31:0] pend_val;

   always @(negedge clk) begin
      int a;
      bus.readdata = pend ? pend_val : $urandom;
      pend = 0;
      a = int'(bus.op_address);
      if (bus.write && a == 0) m_reads = 0;
      if (bus.read) begin
         pend = 1;
         if (a == 0) begin
            m_reads++;
            pend_val = (m_reads >= m_found_after) ? 32'h2 : 32'h1;
         end else if (a == 1) begin
            pend_val = m_nonce;
         end else if (a - 2 < H) begin
            pend_val = m_hash[a-2];
         end else begin
            pend_val = 32'hDEADBEEF;
         end
      end
   end

   // ---------------- downstream ready ----------------
   bit hold_ready = 0;
   bit rand_ready = 0;
   bit stall_en = 0;
   int stall_left = 0;
   int words_seen = 0;

   always @(posedge clk) begin
      #1;
      if (hold_ready) bus.res_ready = 1'b0;
      else if (stall_en && words_seen == 2 && stall_left > 0) begin
         bus.res_ready = 1'b0;
         if (bus.res_valid) stall_left--;
      end else bus.res_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   // ---------------- monitor ----------------
   int cyc = 0;
   int status_reads = 0, kicks = 0, done_cnt = 0, timeouts = 0, stall_cycles = 0;
   int last_stat_cyc = -1;
   bit prev_read = 0, prev_stall = 0, prev_abort = 0;
   logic [31:0] prev_data;
   bit prev_last;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst) begin
         prev_read = 0; prev_stall = 0; prev_abort = 0; last_stat_cyc = -1;
      end else begin
         if (bus.read || bus.write) begin
            chk("rw_exclusive", bus.read & bus.write, 0);
            if (exp_acc.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_access got wr=%0d addr=%0d expected none", bus.write, bus.op_address);
            end else begin
               acc_t a;
               a = exp_acc.pop_front();
               chk("acc_kind", bus.write, a.wr);
               chk("acc_addr", bus.op_address, a.addr);
            end
            if (bus.write && bus.op_address == ADDR_STATUS) begin
               kicks++;
               last_stat_cyc = -1;
            end
         end
         if (bus.read) chk("read_one_cycle", prev_read, 0);
         if (bus.read && bus.op_address == ADDR_STATUS) begin
            status_reads++;
            if (last_stat_cyc >= 0) chk("poll_spacing", cyc - last_stat_cyc, P + 1);
            last_stat_cyc = cyc;
         end
         if (bus.res_valid) chk("no_read_while_valid", bus.read, 0);
         if (prev_stall && !prev_abort) begin
            chk("stall_valid_held", bus.res_valid, 1);
            chk("stall_data_stable", bus.res_data, prev_data);
            chk("stall_last_stable", bus.res_last, prev_last);
         end
         if (bus.res_valid && !bus.res_ready) stall_cycles++;
         if (bus.res_valid && bus.res_ready) begin
            if (exp_words.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_word got=%0h expected none", bus.res_data);
            end else begin
               word_t w;
               w = exp_words.pop_front();
               chk("word_data", bus.res_data, w.d);
               chk("word_last", bus.res_last, w.last);
            end
            words_seen++;
         end
         if (done) begin
            done_cnt++;
            chk("done_with_clear", {bus.write, bus.op_address}, {1'b1, ADDR_NONCE});
         end
         if (timeout) begin
            timeouts++;
            chk("timeout_with_clear", {bus.write, bus.op_address}, {1'b1, ADDR_NONCE});
         end
         prev_read  = bus.read;
         prev_stall = bus.res_valid && !bus.res_ready;
         prev_abort = abort;
         prev_data  = bus.res_data;
         prev_last  = bus.res_last;
      end
   end

   // ---------------- job driver ----------------
   task automatic run_job(input int found_after, input bit expect_to, input bit extra_starts);
      int n, nreads, d0, t0, s0, k0;
      m_found_after = expect_to ? 1000000 : found_after;
      m_nonce = $urandom;
      for (int h = 0; h < H; h++) m_hash[h] = $urandom;
      nreads = expect_to ? TP : found_after;
      exp_acc.push_back('{wr: 1'b1, addr: 5'd0});
      for (int i = 0; i < nreads; i++) exp_acc.push_back('{wr: 1'b0, addr: 5'd0});
      if (!expect_to) begin
         for (int i = 0; i <= H; i++) begin
            exp_acc.push_back('{wr: 1'b0, addr: 5'(1 + i)});
            exp_words.push_back('{d: (i == 0) ? m_nonce : m_hash[i-1], last: (i == H)});
         end
      end
      exp_acc.push_back('{wr: 1'b1, addr: 5'd1});
      d0 = done_cnt; t0 = timeouts; s0 = status_reads; k0 = kicks;
      words_seen = 0; stall_cycles = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("kick_write", bus.write, 1);
      chk("kick_addr", bus.op_address, 0);
      chk("busy_set", busy, 1);
      n = 0;
      while (busy && n < 3000) begin
         @(posedge clk); #1;
         n++;
         start = extra_starts && (done || n == 3);
      end
      start = 1'b0;
      chk("job_ends_in_budget", busy, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("status_reads", status_reads - s0, nreads);
      chk("done_pulses", done_cnt - d0, expect_to ? 0 : 1);
      chk("timeout_pulses", timeouts - t0, expect_to ? 1 : 0);
      chk("kicks_per_job", kicks - k0, 1);
      chk("acc_queue_drained", exp_acc.size(), 0);
      chk("word_queue_drained", exp_words.size(), 0);
      chk("idle_after_job", busy, 0);
   endtask

   initial begin
      int n, d0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_read", bus.read, 0);
      chk("rst_write", bus.write, 0);
      chk("rst_addr", bus.op_address, 0);
      chk("rst_valid", bus.res_valid, 0);
      chk("rst_last", bus.res_last, 0);

      // reset while a status read is on the bus
      rst = 1'b0;
      m_found_after = 1000000;
      exp_acc.push_back('{wr: 1'b1, addr: 5'd0});
      exp_acc.push_back('{wr: 1'b0, addr: 5'd0});
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      while (!bus.read && n < 50) begin @(posedge clk); #1; n++; end
      chk("saw_poll_read", bus.read, 1);
      rst = 1'b1;
      #1;
      chk("rst_drops_read", bus.read, 0);
      chk("rst_drops_busy", busy, 0);
      exp_acc.delete();
      exp_words.delete();
      @(posedge clk); #1 rst = 1'b0;
      run_job(3, 0, 0);

      // poll spacing, 9 words, last flag, clear and done
      rand_ready = 0;
      run_job(3, 0, 0);

      // 10-cycle stall on word 2
      stall_en = 1; stall_left = 10;
      run_job(2, 0, 0);
      chk("stall_len", stall_cycles, 10);
      stall_en = 0;

      // abort while a word is presented
      hold_ready = 1;
      m_found_after = 1;
      m_nonce = $urandom;
      exp_acc.push_back('{wr: 1'b1, addr: 5'd0});
      exp_acc.push_back('{wr: 1'b0, addr: 5'd0});
      exp_acc.push_back('{wr: 1'b0, addr: 5'd1});
      d0 = done_cnt;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      while (!bus.res_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("abort_reached_emit", bus.res_valid, 1);
      chk("abort_emit_data", bus.res_data, m_nonce);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      chk("abort_valid", bus.res_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_acc_seen", exp_acc.size(), 0);
      exp_words.delete();
      hold_ready = 0;
      repeat (12) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt - d0, 0);

      // abort wins over start in IDLE
      abort = 1'b1; start = 1'b1;
      @(posedge clk); #1 abort = 1'b0; start = 1'b0;
      chk("abort_beats_start", busy, 0);
      repeat (3) @(posedge clk);

      // start while busy and in the done cycle
      rand_ready = 1;
      run_job(2, 0, 1);

      for (int j = 0; j < 4; j++) run_job($urandom_range(1, 3), 0, 0);

`ifdef ZAVALA_POLL_TIMEOUT_EN
      run_job(0, 1, 0);
`else
      chk("timeout_never", timeouts, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=stuck expected=finish checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
